// File: rtl/isquare_pipe.sv
// isquare_pipe: pipelined 16-bit unsigned squarer (y = x*x) using shift-and-add over the
// multiplier bits, spread over n_pipe_stages register stages with valid-gated data registers.
module isquare_pipe #(
  parameter int n_pipe_stages = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [15:0] x,
  output logic        y_vld,
  output logic [31:0] y
);

  localparam int bits_per_stage = 16 / n_pipe_stages;
  localparam int last_stage     = n_pipe_stages - 1;

  for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
    localparam int base = s * bits_per_stage;

    logic        vld_in;
    logic [15:0] op_in;
    logic [31:0] acc_in;
    logic [31:0] acc_next;
    logic        vld_q;
    logic [31:0] acc_q;

    if (s == 0) begin : g_first
      assign vld_in = x_vld;
      assign op_in  = x;
      assign acc_in = '0;
    end else begin : g_rest
      assign vld_in = g_stage[s-1].vld_q;
      assign op_in  = g_stage[s-1].g_op.op_q;
      assign acc_in = g_stage[s-1].acc_q;
    end

    // Add the shifted operand for each multiplier bit this stage owns, LSB first.
    always_comb begin
      acc_next = acc_in;
      for (int j = 0; j < bits_per_stage; j++) begin
        if (op_in[base + j]) begin
          acc_next = acc_next + ({16'b0, op_in} << (base + j));
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_in;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
      end else if (vld_in) begin
        acc_q <= acc_next;
      end
    end

    // The final stage has no consumer for the operand, so only earlier stages keep a copy.
    if (s < last_stage) begin : g_op
      logic [15:0] op_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          op_q <= '0;
        end else if (vld_in) begin
          op_q <= op_in;
        end
      end
    end
  end

  assign y_vld = g_stage[last_stage].vld_q;
  assign y     = g_stage[last_stage].acc_q;

endmodule
